regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a per-register pending-write scoreboard. Next-generation replacement for the single-write, dual-read integer register file in the single-cycle core. Width, depth and read/write port counts are configurable, and entry 0 stays hardwired to zero. The scoreboard lets multi-cycle units (multiplier, load unit) mark a destination register busy at issue and release it at writeback.

## Interface
- XLEN, default 32: data width of each entry.
- DEPTH, default 32: entry count; power of two, ≥2. AW = $clog2(DEPTH).
- NR, default 2: read ports.
- NW, default 2: write ports; higher index has priority.
- clk  in  1: clock, rising edge.
- rst  in  1: reset; asynchronous, active-high.
- raddr  in  NR*AW: read addresses, port i at [i*AW +: AW].
- rdata  out  NR*XLEN: read data, port i at [i*XLEN +: XLEN].
- rbusy  out  NR: entry at raddr[i] has a pending write.
- we  in  NW: write enables.
- waddr  in  NW*AW: write addresses.
- wdata  in  NW*XLEN: write data.
- set_en  in  1: mark set_addr busy (issue of a multi-cycle op).
- set_addr  in  AW: register to mark busy.

## Operation
- Storage: DEPTH×XLEN flops. Reset (async) clears every entry and every busy bit to 0.
- Entry 0:
  - Reads return 0 and rbusy=0.
  - Writes to it and set_en on it are ignored.
- Reads are combinational. rdata[i] = entry[raddr[i]], subject to bypass (see Configuration).
- Writes:
  - Take effect on the rising edge for every port with we=1 and waddr≠0.
  - If two ports target the same address in one cycle, the highest-index port's data is stored. No error is flagged.
- Scoreboard, busy[DEPTH], updated on the rising edge:
  - Any we[j]=1 with waddr[j]=a clears busy[a].
  - set_en=1 with set_addr=a sets busy[a].
  - Set and clear of the same address in one cycle: set wins. This models a new issue overtaking an old writeback.
  - set_en on an already-busy entry leaves it busy (no count, no error).
- rbusy[i] = busy[raddr[i]], subject to bypass.
- While rst is asserted: rdata = 0 on all ports, rbusy = 0, and writes and sets are ignored.

## Timing
- Read latency 0 cycles (combinational from raddr). Write latency: visible on the cycle after the write edge.
- Busy set at edge N: rbusy=1 from cycle N+1.
- Busy clear at edge N (no bypass): rbusy=0 from cycle N+1.
- Reset assertion: entries and busy bits clear immediately, without a clock. Deassertion is synchronised externally. The first write is accepted on the first rising edge with rst low.
- Critical path: NW-way address compare plus write-priority mux plus DEPTH:1 read mux. There is no internal pipelining.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A same-cycle write to raddr[i]≠0 forwards to rdata[i], using the highest-index matching write port.
  - rbusy[i] is forced to 0 in that cycle unless set_en targets the same address.
  - Read-after-write and release-on-writeback therefore complete in the writeback cycle.
- Not defined:
  - rdata and rbusy reflect registered state only.
  - A same-cycle write is seen one cycle later, and rbusy drops one cycle after the write.

## Structure
- Package regfile_pkg holds:
  - default XLEN/DEPTH/NR/NW constants;
  - the zero-register index constant (0);
  - a function returning the winning write-port index for an address.
- Sub-module regfile_scoreboard holds the busy[DEPTH] vector and its set/clear priority logic. It outputs the busy vector; regfile_mp indexes it per read port.
- Storage, write priority, read mux and bypass stay in regfile_mp.

## Test plan
1. Reset mid-stream: write 0xDEADBEEF to r5, assert rst asynchronously between edges. Required: rdata on r5 reads 0 immediately, and rbusy is 0 for all entries.
2. Entry 0: we[0]=1, waddr=0, wdata=0xFFFFFFFF; also set_en=1, set_addr=0. Required next cycle: read r0 → 0, rbusy=0.
3. Write collision: we=2'b11, both waddr=7, wdata0=0x11, wdata1=0x22. Required next cycle: read r7 → 0x22.
4. Scoreboard: set_en on r9, then 3 idle cycles, then write r9=0x55.
   - Required: rbusy=1 for 3 cycles.
   - With REGFILE_BYPASS_EN: rdata=0x55 and rbusy=0 in the write cycle.
   - Without it: both change on the following cycle.
5. Set/clear race: r12 busy; in one cycle write r12=0x1 and set_en r12. Required: r12 reads 0x1 afterwards with rbusy still 1.
6. Parametrised build with XLEN=64, DEPTH=16, NR=3, NW=1: write 0x0123456789ABCDEF to r15, read it on all three ports. Required: all three return the value the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and write-port priority helper for the multi-port register file.
package regfile_pkg;
    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned NR_DEF    = 2;
    localparam int unsigned NW_DEF    = 2;
    localparam int unsigned ZERO_REG  = 0;
    localparam int unsigned MAX_PORTS = 16;

    typedef logic [MAX_PORTS-1:0] port_hit_t;

    // hit[j] = write port j targets the address in question; highest index wins.
    function automatic int unsigned win_port(input port_hit_t hit);
        win_port = 0;
        for (int unsigned j = 0; j < MAX_PORTS; j++) begin
            if (hit[j]) win_port = j;
        end
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard-set bus of the multi-port register file.
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NR    = 2,
    parameter int unsigned NW    = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NR*AW-1:0]   raddr;
    logic [NR*XLEN-1:0] rdata;
    logic [NR-1:0]      rbusy;
    logic [NW-1:0]      we;
    logic [NW*AW-1:0]   waddr;
    logic [NW*XLEN-1:0] wdata;
    logic               set_en;
    logic [AW-1:0]      set_addr;

    modport master (
        output raddr, we, waddr, wdata, set_en, set_addr,
        input  rdata, rbusy
    );
    modport slave (
        input  raddr, we, waddr, wdata, set_en, set_addr,
        output rdata, rbusy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write busy vector: writeback clears, issue sets, set wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned NW    = NW_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    we_i,
    input  logic [NW*AW-1:0] waddr_i,
    input  logic             set_en_i,
    input  logic [AW-1:0]    set_addr_i,
    output logic [DEPTH-1:0] busy_o
);
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NW; j++) begin
            if (we_i[j]) busy_d[waddr_i[j*AW +: AW]] = 1'b0;
        end
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hardwired to zero and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes (data and busy release) to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned NR    = NR_DEF,
    parameter int unsigned NW    = NW_DEF
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0]    mem_q [DEPTH];
    logic [XLEN-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0]   busy;
    port_hit_t          whit;
    logic [NR*XLEN-1:0] rdata_c;
    logic [NR-1:0]      rbusy_c;
    logic [AW-1:0]      ra;
    logic [XLEN-1:0]    rd;
    logic               rb;
`ifdef REGFILE_BYPASS_EN
    port_hit_t          rhit;
`endif

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NW    (NW),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .we_i       (bus.we),
        .waddr_i    (bus.waddr),
        .set_en_i   (bus.set_en),
        .set_addr_i (bus.set_addr),
        .busy_o     (busy)
    );

    // Entry 0 is never loaded, so it stays at its reset value of zero.
    always_comb begin
        mem_d = mem_q;
        whit  = '0;
        for (int unsigned a = 1; a < DEPTH; a++) begin
            whit = '0;
            for (int unsigned j = 0; j < NW; j++) begin
                whit[j] = bus.we[j] && (bus.waddr[j*AW +: AW] == AW'(a));
            end
            if (|whit) mem_d[a] = bus.wdata[win_port(whit)*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned a = 0; a < DEPTH; a++) mem_q[a] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        ra      = '0;
        rd      = '0;
        rb      = 1'b0;
`ifdef REGFILE_BYPASS_EN
        rhit    = '0;
`endif
        for (int unsigned i = 0; i < NR; i++) begin
            ra = bus.raddr[i*AW +: AW];
            rd = mem_q[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            rhit = '0;
            for (int unsigned j = 0; j < NW; j++) begin
                rhit[j] = bus.we[j] && (bus.waddr[j*AW +: AW] == ra);
            end
            // A writeback releases the entry unless a new issue grabs it this cycle.
            if (|rhit) begin
                rd = bus.wdata[win_port(rhit)*XLEN +: XLEN];
                rb = bus.set_en && (bus.set_addr == ra);
            end
`endif
            if (rst || ra == AW'(ZERO_REG)) begin
                rd = '0;
                rb = 1'b0;
            end
            rdata_c[i*XLEN +: XLEN] = rd;
            rbusy_c[i]              = rb;
        end
    end

    assign bus.rdata = rdata_c;
    assign bus.rbusy = rbusy_c;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x32 2R/2W build plus a 64-bit 16-entry 3R/1W build.
module tb_regfile_mp;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2)) bus ();
    regfile_mp_if #(.XLEN(64), .DEPTH(16), .NR(3), .NW(1)) bus2 ();

    regfile_mp #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    regfile_mp #(.XLEN(64), .DEPTH(16), .NR(3), .NW(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        int          cyc;
        int          dut;
        int          port;
        logic [63:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due in the current cycle, mid-cycle.
    initial begin
        exp_t        e;
        logic [63:0] ad;
        logic        ab;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    if (e.dut == 0) begin
                        ad = 64'(bus.rdata[e.port*32 +: 32]);
                        ab = bus.rbusy[e.port];
                    end else begin
                        ad = bus2.rdata[e.port*64 +: 64];
                        ab = bus2.rbusy[e.port];
                    end
                    if (ad !== e.data || ab !== e.busy) begin
                        errors++;
                        $display("FAIL %s: port %0d got data=%h busy=%b, expected data=%h busy=%b",
                                 e.name, e.port, ad, ab, e.data, e.busy);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.we       = '0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.set_en   = 1'b0;
        bus.set_addr = '0;
        bus2.we       = '0;
        bus2.waddr    = '0;
        bus2.wdata    = '0;
        bus2.set_en   = 1'b0;
        bus2.set_addr = '0;
    endtask

    task automatic wr(input int p, input int unsigned a, input logic [31:0] v);
        bus.we[p]               = 1'b1;
        bus.waddr[p*5 +: 5]     = a[4:0];
        bus.wdata[p*32 +: 32]   = v;
    endtask

    task automatic setb(input int unsigned a);
        bus.set_en   = 1'b1;
        bus.set_addr = a[4:0];
    endtask

    // Drives the read address for the current cycle and queues the expected response.
    task automatic exp_rd(input int d, input int p, input int unsigned addr,
                          input logic [63:0] data, input logic busy, input string name);
        exp_t e;
        if (d == 0) bus.raddr[p*5 +: 5]  = addr[4:0];
        else        bus2.raddr[p*4 +: 4] = addr[3:0];
        e.cyc  = cyc;
        e.dut  = d;
        e.port = p;
        e.data = data;
        e.busy = busy;
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        clr();
        bus.raddr  = '0;
        bus2.raddr = '0;
        rst = 1'b1;
        tick();
        tick();
        exp_rd(0, 0, 5, 64'h0, 1'b0, "reset_r5");
        exp_rd(0, 1, 31, 64'h0, 1'b0, "reset_r31");
        tick();
        rst = 1'b0;

        // Write r5, mark r6 busy, then assert reset between edges.
        wr(0, 5, 32'hDEADBEEF);
        setb(6);
        tick();
        clr();
        exp_rd(0, 0, 5, 64'hDEADBEEF, 1'b0, "r5_written");
        exp_rd(0, 1, 6, 64'h0, 1'b1, "r6_busy");
        tick();
        #2 rst = 1'b1;
        exp_rd(0, 0, 5, 64'h0, 1'b0, "async_rst_r5");
        exp_rd(0, 1, 6, 64'h0, 1'b0, "async_rst_r6_busy");
        wr(0, 5, 32'h00001234);
        setb(7);
        tick();
        rst = 1'b0;
        clr();
        exp_rd(0, 0, 5, 64'h0, 1'b0, "rst_ignores_write");
        exp_rd(0, 1, 7, 64'h0, 1'b0, "rst_ignores_set");
        tick();

        // Entry 0 ignores writes and sets.
        wr(0, 0, 32'hFFFFFFFF);
        setb(0);
        tick();
        clr();
        exp_rd(0, 0, 0, 64'h0, 1'b0, "r0_hardwired");
        tick();

        // Same-address write collision: port 1 wins.
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        exp_rd(0, 1, 7, BYP ? 64'h22 : 64'h0, 1'b0, "collide_same_cycle");
        tick();
        clr();
        exp_rd(0, 0, 7, 64'h22, 1'b0, "collide_next_cycle");
        tick();

        // Busy for three idle cycles, released by the writeback.
        setb(9);
        tick();
        clr();
        for (int k = 0; k < 3; k++) begin
            exp_rd(0, 0, 9, 64'h0, 1'b1, "r9_busy_idle");
            tick();
        end
        wr(0, 9, 32'h55);
        exp_rd(0, 0, 9, BYP ? 64'h55 : 64'h0, BYP ? 1'b0 : 1'b1, "r9_wb_cycle");
        tick();
        clr();
        exp_rd(0, 0, 9, 64'h55, 1'b0, "r9_after_wb");
        tick();

        // Set and clear of r12 in one cycle: set wins.
        setb(12);
        tick();
        clr();
        exp_rd(0, 0, 12, 64'h0, 1'b1, "r12_busy");
        tick();
        wr(1, 12, 32'h1);
        setb(12);
        exp_rd(0, 1, 12, BYP ? 64'h1 : 64'h0, 1'b1, "race_cycle");
        tick();
        clr();
        exp_rd(0, 0, 12, 64'h1, 1'b1, "race_after");
        tick();
        wr(1, 12, 32'h2);
        tick();
        clr();
        exp_rd(0, 0, 12, 64'h2, 1'b0, "r12_released");
        wr(1, 3, 32'hA5A50F0F);
        tick();
        clr();
        exp_rd(0, 1, 3, 64'hA5A50F0F, 1'b0, "wport1_r3");
        tick();

        // 64-bit, 16-entry, 3-read, 1-write build.
        bus2.we    = 1'b1;
        bus2.waddr = 4'd15;
        bus2.wdata = 64'h0123456789ABCDEF;
        tick();
        clr();
        for (int p = 0; p < 3; p++) begin
            exp_rd(1, p, 15, 64'h0123456789ABCDEF, 1'b0, "wide_r15");
        end
        tick();
        tick();
        tick();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
